// File: rtl/aes_out_pkg.sv
// Shared types and constants for the AES ciphertext word-drain block.
package aes_out_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int unsigned words_per_blk(input int unsigned word_w);
    return BLK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_out_word_mux.sv
// Selects one WORD_W slice of a 128-bit block by word index, MSW- or LSW-first.
module aes_out_word_mux
  import aes_out_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MSW_FIRST = 1,
  parameter int unsigned IDX_W     = $clog2(BLK_W / WORD_W)
) (
  input  logic [BLK_W-1:0]  blk,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned WORDS = words_per_blk(WORD_W);

  logic [IDX_W-1:0] sel;

  // Index 0 maps to the top slice when sending most-significant word first.
  always_comb begin
    sel = idx;
    if (MSW_FIRST != 0) sel = IDX_W'(WORDS - 1) - idx;
  end

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (IDX_W'(i) == sel) word = blk[i*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/aes_text_out_drain.sv
// Drains 128-bit cipher blocks as WORD_W words over a valid/ready port, one-block pending buffer.
// Optional AES_OUT_PARITY_EN adds out_par, even parity per out_data byte.
module aes_text_out_drain
  import aes_out_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MSW_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              done,
  input  logic [BLK_W-1:0]  text_out,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
`ifdef AES_OUT_PARITY_EN
  output logic [WORD_W/8-1:0] out_par,
`endif
  output logic              overrun
);

  localparam int unsigned WORDS = words_per_blk(WORD_W);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   main_q, main_d;
  logic [BLK_W-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               ovr_d;
  logic               xfer, last_xfer;
  logic [WORD_W-1:0]  word_d;

  assign xfer      = (state_q == DRAIN) & out_ready;
  assign last_xfer = xfer & (idx_q == LAST_IDX);

  // Next-state: main/pending hand-off, index advance, overrun tracking.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    main_d     = main_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ld ? 1'b0 : overrun;

    unique case (state_q)
      IDLE: begin
        if (done) begin
          main_d  = text_out;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) idx_d = idx_q + IDX_W'(1);
        if (last_xfer) begin
          idx_d = '0;
          if (pend_vld_q) begin
            main_d = pend_q;
            if (done) pend_d = text_out;
            else      pend_vld_d = 1'b0;
          end else if (done) begin
            main_d = text_out;
          end else begin
            state_d = IDLE;
          end
        end else if (done) begin
          if (!pend_vld_q) begin
            pend_d     = text_out;
            pend_vld_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  aes_out_word_mux #(
    .WORD_W    (WORD_W),
    .MSW_FIRST (MSW_FIRST),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .blk  (main_d),
    .idx  (idx_d),
    .word (word_d)
  );

  // Control state and registered outputs; outputs are computed from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_vld_q <= 1'b0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_vld_q <= pend_vld_d;
      overrun    <= ovr_d;
      out_valid  <= (state_d == DRAIN);
      out_last   <= (state_d == DRAIN) && (idx_d == LAST_IDX);
      out_data   <= (state_d == DRAIN) ? word_d : '0;
      busy       <= (state_d == DRAIN) | pend_vld_d;
    end
  end

  // Block buffers carry no reset; validity lives in the control state.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    pend_q <= pend_d;
  end

`ifdef AES_OUT_PARITY_EN
  always_comb begin
    out_par = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++) out_par[b] = ^out_data[b*8 +: 8];
  end
`endif

endmodule

// File: tb/tb_aes_text_out_drain.sv
// Directed self-checking bench for aes_text_out_drain (MSW-first and LSW-first instances).
module tb_aes_text_out_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic         done;
  logic [127:0] text_out;
  logic         ready_m, ready_l;

  logic [31:0]  od_m, od_l;
  logic         ov_m, ov_l, ol_m, ol_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef AES_OUT_PARITY_EN
  logic [3:0]   par_m, par_l;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] BLK_C = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  logic [31:0] a_msw [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [31:0] a_lsw [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
  logic [31:0] b_msw [4] = '{32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
  logic [31:0] c_msw [4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0};

  always #5 clk = ~clk;

  aes_text_out_drain #(.WORD_W(32), .MSW_FIRST(1)) dut_m (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .done      (done),
    .text_out  (text_out),
    .out_data  (od_m),
    .out_valid (ov_m),
    .out_ready (ready_m),
    .out_last  (ol_m),
    .busy      (busy_m),
`ifdef AES_OUT_PARITY_EN
    .out_par   (par_m),
`endif
    .overrun   (ovr_m)
  );

  aes_text_out_drain #(.WORD_W(32), .MSW_FIRST(0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .done      (done),
    .text_out  (text_out),
    .out_data  (od_l),
    .out_valid (ov_l),
    .out_ready (ready_l),
    .out_last  (ol_l),
    .busy      (busy_l),
`ifdef AES_OUT_PARITY_EN
    .out_par   (par_l),
`endif
    .overrun   (ovr_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One-cycle done pulse; outputs reflect it after the following edge.
  task automatic pulse_done(input logic [127:0] blk);
    done     = 1'b1;
    text_out = blk;
    step();
    done     = 1'b0;
  endtask

  task automatic chk_word_m(input string tag, input logic [31:0] w, input logic last);
    check({tag, ".valid"}, 64'(ov_m), 64'(1'b1));
    check({tag, ".data"},  64'(od_m), 64'(w));
    check({tag, ".last"},  64'(ol_m), 64'(last));
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; done = 1'b0; text_out = '0;
    ready_m = 1'b1; ready_l = 1'b1;
    #2;
    do_reset();

    // Reset state
    check("rst.valid",   64'(ov_m),   64'(0));
    check("rst.data",    64'(od_m),   64'(0));
    check("rst.last",    64'(ol_m),   64'(0));
    check("rst.busy",    64'(busy_m), 64'(0));
    check("rst.overrun", 64'(ovr_m),  64'(0));
`ifdef AES_OUT_PARITY_EN
    check("rst.par",     64'(par_m),  64'(0));
`endif

    // Basic MSW-first drain at full rate
    pulse_done(BLK_A);
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("msw.w%0d", k), a_msw[k], k == 3);
      step();
    end
    check("msw.idle_valid", 64'(ov_m),   64'(0));
    check("msw.idle_busy",  64'(busy_m), 64'(0));

    // LSW-first with stalls every other cycle
    do_reset();
    pulse_done(BLK_A);
    for (int k = 0; k < 4; k++) begin
      ready_l = 1'b0;
      check($sformatf("lsw.w%0d", k), 64'(od_l), 64'(a_lsw[k]));
      step();
      check($sformatf("lsw.stall_w%0d", k), 64'(od_l), 64'(a_lsw[k]));
      check($sformatf("lsw.stall_last%0d", k), 64'(ol_l), 64'(k == 3));
      check($sformatf("lsw.stall_valid%0d", k), 64'(ov_l), 64'(1));
      ready_l = 1'b1;
      step();
    end
    check("lsw.idle_valid", 64'(ov_l), 64'(0));

    // Overrun: three blocks with sink stalled
    do_reset();
    ready_m = 1'b0;
    pulse_done(BLK_A);
    pulse_done(BLK_B);
    check("ovr.before_drop", 64'(ovr_m), 64'(0));
    pulse_done(BLK_C);
    check("ovr.set",  64'(ovr_m),  64'(1));
    check("ovr.busy", 64'(busy_m), 64'(1));
    check("ovr.head", 64'(od_m),   64'(a_msw[0]));
    ld = 1'b1; done = 1'b1; text_out = BLK_C;
    step();
    ld = 1'b0; done = 1'b0;
    check("ovr.set_wins", 64'(ovr_m), 64'(1));
    ld = 1'b1;
    step();
    ld = 1'b0;
    check("ovr.cleared", 64'(ovr_m), 64'(0));
    ready_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("ovr.a%0d", k), a_msw[k], k == 3);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("ovr.b%0d", k), b_msw[k], k == 3);
      step();
    end
    check("ovr.idle_valid", 64'(ov_m),   64'(0));
    check("ovr.idle_busy",  64'(busy_m), 64'(0));

    // done coincident with last-word transfer, pending full
    do_reset();
    ready_m = 1'b0;
    pulse_done(BLK_A);
    pulse_done(BLK_B);
    ready_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_word_m($sformatf("coin.a%0d", k), a_msw[k], 1'b0);
      step();
    end
    chk_word_m("coin.a3", a_msw[3], 1'b1);
    pulse_done(BLK_C);
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("coin.b%0d", k), b_msw[k], k == 3);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("coin.c%0d", k), c_msw[k], k == 3);
      step();
    end
    check("coin.overrun",    64'(ovr_m), 64'(0));
    check("coin.idle_valid", 64'(ov_m),  64'(0));

    // Reset mid-drain discards the block
    do_reset();
    ready_m = 1'b1;
    pulse_done(BLK_A);
    chk_word_m("mid.a0", a_msw[0], 1'b0);
    step();
    chk_word_m("mid.a1", a_msw[1], 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid.valid", 64'(ov_m),   64'(0));
    check("mid.busy",  64'(busy_m), 64'(0));
    check("mid.data",  64'(od_m),   64'(0));
    step();
    check("mid.still_idle", 64'(ov_m), 64'(0));
    pulse_done(BLK_B);
    for (int k = 0; k < 4; k++) begin
      chk_word_m($sformatf("mid.b%0d", k), b_msw[k], k == 3);
      step();
    end

`ifdef AES_OUT_PARITY_EN
    // Byte parity of 0x01030000 -> only top byte odd
    do_reset();
    pulse_done(128'h01030000_00000000_00000000_00000000);
    check("par.data", 64'(od_m),  64'(32'h01030000));
    check("par.bits", 64'(par_m), 64'(4'b1000));
    for (int k = 0; k < 4; k++) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
